// File: rtl/basic_adder.sv
// basic_adder: operand select plus 32-bit adder for the execute stage.
//
// Decodes the I/S/B/U/J immediates from the issue packet's instruction word, selects operand A
// (rs1 / NPC / PC / zero) and operand B (rs2 / immediate / zero) using the decoder's selects, and
// returns their modulo-2^32 sum combinationally. A registered copy of the sum plus a one-cycle
// done flag serve consumers that sample a cycle later.
//
// Ports:
//   clock    - single clock, rising-edge state updates
//   reset    - synchronous, active-high; clears result_q and done
//   is_pack  - issue packet (operand values, PC/NPC, instruction word, operand selects)
//   en       - capture request for the registered outputs
//   result   - combinational opa + opb; independent of clock, reset and en
//   result_q - result registered on a cycle with en high (and reset low)
//   done     - high the cycle after en was sampled high (and reset low)

package basic_adder_pkg;

  typedef logic [31:0] ADDR;
  typedef logic [31:0] DATA;
  typedef logic [31:0] INST;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'h0,
    OPA_IS_NPC  = 2'h1,
    OPA_IS_PC   = 2'h2,
    OPA_IS_ZERO = 2'h3
  } ALU_OPA_SELECT;

  // Encodings above OPB_IS_J_IMM are unused by the decoder and select zero.
  typedef enum logic [3:0] {
    OPB_IS_RS2   = 4'h0,
    OPB_IS_I_IMM = 4'h1,
    OPB_IS_S_IMM = 4'h2,
    OPB_IS_B_IMM = 4'h3,
    OPB_IS_U_IMM = 4'h4,
    OPB_IS_J_IMM = 4'h5
  } ALU_OPB_SELECT;

  typedef struct packed {
    ADDR           PC;
    ADDR           NPC;
    INST           inst;
    ALU_OPA_SELECT opa_select;
    ALU_OPB_SELECT opb_select;
    logic          valid;
  } DECODED_VALS;

  typedef struct packed {
    DECODED_VALS decoded_vals;
    logic [4:0]  dest_reg;
  } DECODED_PACKET;

  typedef struct packed {
    DATA           rs1_value;
    DATA           rs2_value;
    DECODED_PACKET decoded_vals;
  } ISSUE_PACKET;

endpackage

module basic_adder
  import basic_adder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  ISSUE_PACKET is_pack,
  input  logic        en,
  output ADDR         result,
  output logic [31:0] result_q,
  output logic        done
);

  INST inst;
  ADDR pc;
  ADDR npc;
  ALU_OPA_SELECT opa_select;
  ALU_OPB_SELECT opb_select;

  assign inst       = is_pack.decoded_vals.decoded_vals.inst;
  assign pc         = is_pack.decoded_vals.decoded_vals.PC;
  assign npc        = is_pack.decoded_vals.decoded_vals.NPC;
  assign opa_select = is_pack.decoded_vals.decoded_vals.opa_select;
  assign opb_select = is_pack.decoded_vals.decoded_vals.opb_select;

  // Opcode, dest_reg and valid are not needed: the block trusts the decoder's selects.
  logic unused_pack;
  assign unused_pack = ^{inst[6:0], is_pack.decoded_vals.dest_reg,
                         is_pack.decoded_vals.decoded_vals.valid};

  // Immediate decode; all but U are sign-extended from inst[31].
  ADDR i_imm;
  ADDR s_imm;
  ADDR b_imm;
  ADDR u_imm;
  ADDR j_imm;

  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  ADDR opa;
  ADDR opb;

  always_comb begin
    opa = '0;
    case (opa_select)
      OPA_IS_RS1:  opa = is_pack.rs1_value;
      OPA_IS_NPC:  opa = npc;
      OPA_IS_PC:   opa = pc;
      OPA_IS_ZERO: opa = '0;
      default:     opa = '0;
    endcase
  end

  always_comb begin
    opb = '0;
    case (opb_select)
      OPB_IS_RS2:   opb = is_pack.rs2_value;
      OPB_IS_I_IMM: opb = i_imm;
      OPB_IS_S_IMM: opb = s_imm;
      OPB_IS_B_IMM: opb = b_imm;
      OPB_IS_U_IMM: opb = u_imm;
      OPB_IS_J_IMM: opb = j_imm;
      default:      opb = '0;
    endcase
  end

  // Carry out is intentionally dropped.
  assign result = opa + opb;

  // Registered copy; reset wins over en.
  logic [31:0] result_q_d;
  logic        done_d;

  always_comb begin
    result_q_d = result_q;
    done_d     = 1'b0;
    if (en) begin
      result_q_d = result;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      done     <= 1'b0;
    end else begin
      result_q <= result_q_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_basic_adder.sv
module tb_basic_adder;
  import basic_adder_pkg::*;

  logic        clock;
  logic        reset;
  logic        en;
  ISSUE_PACKET is_pack;
  ADDR         result;
  logic [31:0] result_q;
  logic        done;

  int errors = 0;
  int checks = 0;

  basic_adder dut (
    .clock   (clock),
    .reset   (reset),
    .is_pack (is_pack),
    .en      (en),
    .result  (result),
    .result_q(result_q),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pack(input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] npc,
                          input logic [31:0] ins, input logic [1:0] opa,
                          input logic [3:0] opb);
    is_pack = '0;
    is_pack.rs1_value = rs1;
    is_pack.rs2_value = rs2;
    is_pack.decoded_vals.decoded_vals.PC = pc;
    is_pack.decoded_vals.decoded_vals.NPC = npc;
    is_pack.decoded_vals.decoded_vals.inst = ins;
    is_pack.decoded_vals.decoded_vals.opa_select = ALU_OPA_SELECT'(opa);
    is_pack.decoded_vals.decoded_vals.opb_select = ALU_OPB_SELECT'(opb);
    is_pack.decoded_vals.decoded_vals.valid = 1'b1;
  endtask

  // Signed interpretation of an n-bit field as a plain integer.
  function automatic longint sext(input longint val, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - 2 * half : val;
  endfunction

  function automatic longint fld(input logic [31:0] ins, input int lo, input int width);
    return (longint'(ins) >> lo) % (longint'(1) << width);
  endfunction

  // Reference sum built from weighted instruction fields with plain integer arithmetic.
  function automatic logic [31:0] model_sum(input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] pc, input logic [31:0] npc,
                                            input logic [31:0] ins, input int opa,
                                            input int opb);
    longint a;
    longint b;
    longint s;
    case (opa)
      0: a = longint'(rs1);
      1: a = longint'(npc);
      2: a = longint'(pc);
      default: a = 0;
    endcase
    case (opb)
      0: b = longint'(rs2);
      1: b = sext(fld(ins, 20, 12), 12);
      2: b = sext(fld(ins, 25, 7) * 32 + fld(ins, 7, 5), 12);
      3: b = sext(fld(ins, 31, 1) * 4096 + fld(ins, 7, 1) * 2048 + fld(ins, 25, 6) * 32
                  + fld(ins, 8, 4) * 2, 13);
      4: b = fld(ins, 12, 20) * 4096;
      5: b = sext(fld(ins, 31, 1) * 1048576 + fld(ins, 12, 8) * 4096 + fld(ins, 20, 1) * 2048
                  + fld(ins, 21, 10) * 2, 21);
      default: b = 0;
    endcase
    s = (a + b) % 64'sh1_0000_0000;
    if (s < 0) s = s + 64'sh1_0000_0000;
    return s[31:0];
  endfunction

  initial begin
    logic [31:0] r1, r2, pc, npc, ins, exp_sum, exp_rq;
    int          opa, opb;
    logic        exp_done;

    // Reset with an RS1 + RS2 packet; result must track the packet during reset.
    reset = 1'b1;
    en    = 1'b0;
    set_pack(32'h10, 32'h20, 32'h0, 32'h4, 32'h0, 2'd0, 4'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_result_q", result_q, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("rs1_plus_rs2_in_reset", result, 32'h30);

    // Capture 0x30.
    @(negedge clock);
    reset = 1'b0;
    en    = 1'b1;
    @(posedge clock);
    #1;
    check("capture_result_q", result_q, 32'h30);
    check("capture_done", {31'b0, done}, 32'h1);

    // en low: hold result_q, drop done. Backward branch target in the same cycle.
    @(negedge clock);
    en = 1'b0;
    set_pack(32'h0, 32'h0, 32'h100, 32'h104, 32'hFE00_0C80, 2'd2, 4'd3);
    #1;
    check("branch_backward", result, 32'h0000_00F8);
    @(posedge clock);
    #1;
    check("hold_result_q", result_q, 32'h30);
    check("hold_done", {31'b0, done}, 32'h0);

    // Directed combinational cases.
    @(negedge clock);
    set_pack(32'h0, 32'h0, 32'h1000, 32'h1004, 32'h7E00_0F00, 2'd2, 4'd3);
    #1 check("branch_forward", result, 32'h0000_17FE);
    set_pack(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4, 32'h0080_0000, 2'd0, 4'd1);
    #1 check("wrap_i_imm", result, 32'h0000_0004);
    set_pack(32'h0, 32'h0, 32'h0, 32'h4, 32'hFFDF_F000, 2'd2, 4'd5);
    #1 check("wrap_j_imm", result, 32'hFFFF_FFFC);
    set_pack(32'h55, 32'h66, 32'h0, 32'h4, 32'h1234_5000, 2'd3, 4'd4);
    #1 check("zero_plus_u_imm", result, 32'h1234_5000);
    set_pack(32'h0, 32'h0, 32'h100, 32'h104, 32'hFE00_0E00, 2'd1, 4'd2);
    #1 check("npc_plus_s_imm", result, 32'h0000_0100);
    set_pack(32'h1234, 32'h9999, 32'h0, 32'h4, 32'hFFFF_FFFF, 2'd0, 4'd9);
    #1 check("opb_unused_encoding", result, 32'h1234);

    // Back-to-back captures keep done high.
    @(negedge clock);
    en = 1'b1;
    set_pack(32'h11, 32'h22, 32'h0, 32'h4, 32'h0, 2'd0, 4'd0);
    @(posedge clock);
    #1;
    check("b2b_first_result_q", result_q, 32'h33);
    check("b2b_first_done", {31'b0, done}, 32'h1);
    @(negedge clock);
    set_pack(32'hA0, 32'h0B, 32'h0, 32'h4, 32'h0, 2'd0, 4'd0);
    @(posedge clock);
    #1;
    check("b2b_second_result_q", result_q, 32'hAB);
    check("b2b_second_done", {31'b0, done}, 32'h1);

    // Reset beats en; result keeps tracking the packet.
    @(negedge clock);
    reset = 1'b1;
    en    = 1'b1;
    set_pack(32'h0, 32'h0, 32'h0, 32'h4, 32'h1234_5000, 2'd3, 4'd4);
    @(posedge clock);
    #1;
    check("rst_prio_result_q", result_q, 32'h0);
    check("rst_prio_done", {31'b0, done}, 32'h0);
    check("rst_prio_result", result, 32'h1234_5000);

    // Randomized packets against the arithmetic model, with occasional resets.
    exp_rq   = 32'h0;
    exp_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      r1  = $urandom;
      r2  = $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      npc = pc + 32'd4;
      ins = $urandom;
      opa = $urandom_range(0, 3);
      opb = $urandom_range(0, 7);
      set_pack(r1, r2, pc, npc, ins, opa[1:0], opb[3:0]);
      reset = ($urandom_range(0, 15) == 0);
      en    = $urandom_range(0, 1) == 1;
      exp_sum = model_sum(r1, r2, pc, npc, ins, opa, opb);
      #1 check("rand_result", result, exp_sum);
      if (reset) begin
        exp_rq   = 32'h0;
        exp_done = 1'b0;
      end else if (en) begin
        exp_rq   = exp_sum;
        exp_done = 1'b1;
      end else begin
        exp_done = 1'b0;
      end
      @(posedge clock);
      #1;
      check("rand_result_q", result_q, exp_rq);
      check("rand_done", {31'b0, done}, {31'b0, exp_done});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/basic_adder.md
# basic_adder

Operand-select plus 32-bit adder for the execute stage. Decodes the immediate from the instruction word in an issue packet, picks two operands (register, PC-based, immediate or zero) per the packet's operand selects, and returns the sum combinationally. The branch functional unit uses it to compute the taken target (PC + B-immediate); other FUs reuse it for address and link computations. A registered copy of the result with a done flag is also provided for consumers that sample a cycle later.

## Interface
- No parameters. Widths come from the shared `ADDR` and `DATA` types, both 32 bits.
- `clock`  input  1  — single clock; all state updates on its rising edge.
- `reset`  input  1  — synchronous, active-high.
- `is_pack`  input  `ISSUE_PACKET`  — fields used:
  - `rs1_value` and `rs2_value`.
  - `decoded_vals.decoded_vals.PC`, `.NPC`, `.inst`, `.opa_select` and `.opb_select`.
- `en`  input  1  — capture request for the registered outputs.
- `result`  output  `ADDR` (32)  — combinational sum `opa + opb`.
- `result_q`  output  32  — registered `result`.
- `done`  output  1  — registered; high the cycle after `en` was sampled high.

## Operation
Immediate decode from `inst`; all immediates are sign-extended to 32 bits unless noted:
- I: `inst[31:20]`.
- S: `{inst[31:25], inst[11:7]}`.
- B: `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
- U: `{inst[31:12], 12'b0}`, no extension.
- J: `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.

Operand A by `opa_select`:
- `OPA_IS_RS1` → `rs1_value`.
- `OPA_IS_NPC` → `NPC`.
- `OPA_IS_PC` → `PC`.
- `OPA_IS_ZERO` → 0.
- Any other encoding → 0.

Operand B by `opb_select`:
- `OPB_IS_RS2` → `rs2_value`.
- `OPB_IS_I_IMM`, `OPB_IS_S_IMM`, `OPB_IS_B_IMM`, `OPB_IS_U_IMM`, `OPB_IS_J_IMM` → the matching immediate.
- Any other encoding → 0.

Branch targets are produced by packets with opa = PC and opb = B_IMM. The block does not infer selects from the opcode; it trusts the decoder.

Arithmetic:
- `result = opa + opb`, unsigned 32-bit, modulo 2^32.
- Carry out is discarded and there is no overflow flag.
- Signedness matters only through immediate sign extension.

## Timing
- `result` is purely combinational from `is_pack`, valid in the same cycle with zero latency. It does not depend on `clock`, `reset` or `en`, including during reset.
- Registered path, on each rising edge:
  - If `reset`: `result_q <= 0`, `done <= 0`.
  - Else if `en`: `result_q <= result`, `done <= 1`.
  - Else: `result_q` holds its value, `done <= 0`.
- Reset values: `result_q = 0`, `done = 0`.
- `reset` asserted in the same cycle as `en` wins; no capture occurs.
- Back-to-back `en` captures a new value every cycle, with `done` staying high.
- There is no backpressure and no handshake beyond `en`.

## Test plan
- **Branch target backward:** PC = 0x0000_0100, opa = PC, opb = B_IMM, inst[31]=1, inst[30:25]=6'h3F, inst[11:8]=4'hC, inst[7]=1 (imm = −8) → `result` = 0x0000_00F8 in the same cycle.
- **Branch target forward:** PC = 0x0000_1000, B-imm = +0x7FE (all positive fields set) → `result` = 0x0000_17FE.
- **Wrap-around:**
  - opa = RS1, rs1_value = 0xFFFF_FFFC, opb = I_IMM with imm = 8 → `result` = 0x0000_0004.
  - J_IMM = −4 with PC = 0 → `result` = 0xFFFF_FFFC.
- **Operand coverage:**
  - opa = RS1 (0x10), opb = RS2 (0x20) → 0x30.
  - opa = ZERO, opb = U_IMM with inst[31:12] = 0x12345 → 0x1234_5000.
  - opa = NPC (0x104), opb = S_IMM = −4 → 0x100.
- **Register path:**
  - After reset, `result_q` = 0 and `done` = 0.
  - `en`=1 with result 0x30 → next cycle `result_q` = 0x30, `done` = 1.
  - `en`=0 → `done` = 0 and `result_q` stays 0x30.
- **Reset priority:** `reset`=1 and `en`=1 in the same cycle → next cycle `result_q` = 0, `done` = 0, while `result` continues to track `is_pack`.
